cpu_step_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 16-bit RISC core.
- Owns the program counter and the instruction register.
- Steps every instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives a req/ack memory handshake.
- Issues single-cycle enable strobes to the ALU and register file. Sits between instruction/data memory and the datapath.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/cpu_step_sequencer_if.sv | 31 +++
 rtl/mem_handshake_timer.sv | 38 +++
 rtl/cpu_step_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_cpu_step_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state encoding, opcode constants and width defaults for the step sequencer
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } seq_state_t;

    localparam logic [3:0] OP_ALU_MAX = 4'h7;
    localparam logic [3:0] OP_LOAD    = 4'h8;
    localparam logic [3:0] OP_STORE   = 4'h9;
    localparam logic [3:0] OP_BR      = 4'hA;
    localparam logic [3:0] OP_HALT    = 4'hF;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_ALU_MAX);
    endfunction

endpackage

// File: rtl/cpu_step_sequencer_if.sv
// rtl/cpu_step_sequencer_if.sv - memory req/ack bus between the sequencer (master) and memory (slave)
interface cpu_step_sequencer_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              MEM_ACK;

    modport master (
        output MEM_REQ,
        output MEM_WE,
        output MEM_ADDR,
        input  MEM_RDATA,
        input  MEM_ACK
    );

    modport slave (
        input  MEM_REQ,
        input  MEM_WE,
        input  MEM_ADDR,
        output MEM_RDATA,
        output MEM_ACK
    );

endinterface

// File: rtl/mem_handshake_timer.sv
// rtl/mem_handshake_timer.sv - counts unacknowledged request cycles and flags a timeout
module mem_handshake_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic RST,
    input  logic req,
    input  logic ack,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // The count restarts whenever the request is low or completes, so a
    // back-to-back request after an ack gets a full window of its own.
    always_comb begin
        cnt_d = cnt_q;
        if (!req || ack) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = req && !ack && (cnt_q == LIMIT);

endmodule

// File: rtl/cpu_step_sequencer.sv
// rtl/cpu_step_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback control for the 16-bit core
// Optional single-step input STEP is built when SEQ_SINGLE_STEP_EN is defined.
module cpu_step_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              STEP,
`endif
    cpu_step_sequencer_if.master mem,
    input  logic [ADDR_W-1:0] EA,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_TARGET,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic              ALU_EN,
    output logic              RF_WE,
    output logic              HALTED,
    output logic              ERR,
    output logic [2:0]        STATE
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              err_q, err_d;
`ifdef SEQ_SINGLE_STEP_EN
    logic              step_q, step_d;
`endif

    logic       timeout;
    logic       mem_done;
    logic       at_boundary;
    logic [3:0] opcode;

    assign opcode   = ir_q[DATA_W-1 -: 4];
    assign mem_done = mem_req_q && mem.MEM_ACK;

    mem_handshake_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .req     (mem_req_q),
        .ack     (mem.MEM_ACK),
        .timeout (timeout)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        err_d       = err_q;
        at_boundary = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step_d      = step_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (RUN) begin
                    state_d = ST_FETCH;
`ifdef SEQ_SINGLE_STEP_EN
                end else if (STEP) begin
                    state_d = ST_FETCH;
                    step_d  = 1'b1;
`endif
                end
            end
            ST_FETCH: begin
                if (mem_done) begin
                    ir_d    = mem.MEM_RDATA;
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_alu_op(opcode)) begin
                    state_d = ST_WRITEBACK;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = ST_MEMORY;
                end else if (opcode == OP_BR) begin
                    if (BR_TAKEN) begin
                        pc_d = BR_TARGET;
                    end
                    at_boundary = 1'b1;
                end else if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    at_boundary = 1'b1;
                end
            end
            ST_MEMORY: begin
                if (mem_done) begin
                    if (opcode == OP_LOAD) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        at_boundary = 1'b1;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_WRITEBACK: begin
                at_boundary = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // RUN is only consulted here, so dropping it mid-instruction is harmless.
        if (at_boundary) begin
            state_d = RUN ? ST_FETCH : ST_IDLE;
`ifdef SEQ_SINGLE_STEP_EN
            if (step_q) begin
                state_d = ST_IDLE;
            end
            step_d = 1'b0;
`endif
        end
    end

    // Bus outputs are registered from the next state; the address is captured
    // only on phase entry so it cannot follow EA while a request is waiting.
    always_comb begin
        mem_req_d  = (state_d == ST_FETCH) || (state_d == ST_MEMORY);
        mem_we_d   = (state_d == ST_MEMORY) && (opcode == OP_STORE);
        mem_addr_d = mem_addr_q;
        if (state_d == ST_FETCH && state_q != ST_FETCH) begin
            mem_addr_d = pc_d;
        end else if (state_d == ST_MEMORY && state_q != ST_MEMORY) begin
            mem_addr_d = EA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            err_q      <= err_d;
        end
    end

`ifdef SEQ_SINGLE_STEP_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_d;
        end
    end
`endif

    assign mem.MEM_REQ  = mem_req_q;
    assign mem.MEM_WE   = mem_we_q;
    assign mem.MEM_ADDR = mem_addr_q;

    assign PC     = pc_q;
    assign IR     = ir_q;
    assign ALU_EN = (state_q == ST_EXECUTE);
    assign RF_WE  = (state_q == ST_WRITEBACK);
    assign HALTED = (state_q == ST_HALT);
    assign ERR    = err_q;
    assign STATE  = state_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// tb/tb_cpu_step_sequencer.sv - directed self-checking bench for cpu_step_sequencer
module tb_cpu_step_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] ea;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        alu_en;
    logic        rf_we;
    logic        halted;
    logic        err;
    logic [2:0]  state;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int fetch_delay;
    int mem_delay;

    logic [15:0] imem [logic [15:0]];

    cpu_step_sequencer_if #(.ADDR_W(16), .DATA_W(16)) mem_bus ();

    cpu_step_sequencer #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .MEM_TIMEOUT (15)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .RUN       (run),
`ifdef SEQ_SINGLE_STEP_EN
        .STEP      (step),
`endif
        .mem       (mem_bus),
        .EA        (ea),
        .BR_TAKEN  (br_taken),
        .BR_TARGET (br_target),
        .PC        (pc),
        .IR        (ir),
        .ALU_EN    (alu_en),
        .RF_WE     (rf_we),
        .HALTED    (halted),
        .ERR       (err),
        .STATE     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (imem.exists(a)) return imem[a];
        return 16'hE000;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks after a programmable number of waiting cycles.
    initial begin
        int wcnt;
        int dly;
        wcnt = 0;
        mem_bus.MEM_ACK   = 1'b0;
        mem_bus.MEM_RDATA = '0;
        forever begin
            @(negedge clk);
            if (mem_bus.MEM_REQ === 1'b1) begin
                dly = (state == 3'd4) ? mem_delay : fetch_delay;
                if (wcnt >= dly) begin
                    mem_bus.MEM_ACK   = 1'b1;
                    mem_bus.MEM_RDATA = rd(mem_bus.MEM_ADDR);
                    wcnt = 0;
                end else begin
                    mem_bus.MEM_ACK   = 1'b0;
                    mem_bus.MEM_RDATA = '0;
                    wcnt++;
                end
            end else begin
                mem_bus.MEM_ACK   = 1'b0;
                mem_bus.MEM_RDATA = '0;
                wcnt = 0;
            end
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; ea = '0; br_taken = 1'b0; br_target = '0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        fetch_delay = 0;
        mem_delay   = 0;
        imem[16'h0000] = 16'h1234;
        imem[16'h0001] = 16'h8000;
        imem[16'h0002] = 16'hA000;
        imem[16'h0100] = 16'hA000;
        imem[16'h0101] = 16'h9000;
        imem[16'h0102] = 16'h1111;
        imem[16'h0103] = 16'hA000;
        imem[16'hFFFF] = 16'hE000;
        imem[16'h0040] = 16'hBEEF;

        cyc(2);
        check("rst_state",  16'(state), 16'd0);
        check("rst_pc",     pc, 16'h0000);
        check("rst_ir",     ir, 16'h0000);
        check("rst_req",    16'(mem_bus.MEM_REQ), 16'd0);
        check("rst_we",     16'(mem_bus.MEM_WE), 16'd0);
        check("rst_addr",   mem_bus.MEM_ADDR, 16'h0000);
        check("rst_alu_en", 16'(alu_en), 16'd0);
        check("rst_rf_we",  16'(rf_we), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        check("rst_err",    16'(err), 16'd0);

        rst = 1'b0; run = 1'b1;
        // ALU instruction 0x1234 with zero-wait memory
        cyc(1);
        check("alu_c1_state", 16'(state), 16'd1);
        check("alu_c1_req",   16'(mem_bus.MEM_REQ), 16'd1);
        check("alu_c1_addr",  mem_bus.MEM_ADDR, 16'h0000);
        cyc(1);
        check("alu_c2_state", 16'(state), 16'd2);
        check("alu_c2_ir",    ir, 16'h1234);
        check("alu_c2_pc",    pc, 16'h0001);
        check("alu_c2_req",   16'(mem_bus.MEM_REQ), 16'd0);
        cyc(1);
        check("alu_c3_state", 16'(state), 16'd3);
        check("alu_c3_alu_en", 16'(alu_en), 16'd1);
        ea = 16'h0040; mem_delay = 3;
        cyc(1);
        check("alu_c4_state", 16'(state), 16'd5);
        check("alu_c4_rf_we", 16'(rf_we), 16'd1);
        check("alu_c4_alu_en", 16'(alu_en), 16'd0);
        cyc(1);
        check("alu_c5_state", 16'(state), 16'd1);
        check("alu_c5_addr",  mem_bus.MEM_ADDR, 16'h0001);
        check("alu_c5_rf_we", 16'(rf_we), 16'd0);

        // LOAD 0x8000, EA=0x0040, ack delayed three cycles
        cyc(1);
        check("ld_decode_ir", ir, 16'h8000);
        cyc(1);
        check("ld_exec_state", 16'(state), 16'd3);
        cyc(1);
        check("ld_mem_state", 16'(state), 16'd4);
        check("ld_mem_req",   16'(mem_bus.MEM_REQ), 16'd1);
        check("ld_mem_addr",  mem_bus.MEM_ADDR, 16'h0040);
        check("ld_mem_we",    16'(mem_bus.MEM_WE), 16'd0);
        ea = 16'h0041;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("ld_wait_req",  16'(mem_bus.MEM_REQ), 16'd1);
            check("ld_wait_addr", mem_bus.MEM_ADDR, 16'h0040);
            check("ld_wait_we",   16'(mem_bus.MEM_WE), 16'd0);
        end
        cyc(1);
        check("ld_wb_state", 16'(state), 16'd5);
        check("ld_wb_rf_we", 16'(rf_we), 16'd1);
        check("ld_wb_req",   16'(mem_bus.MEM_REQ), 16'd0);
        mem_delay = 0; br_taken = 1'b1; br_target = 16'h0100;

        // BRANCH taken to 0x0100, then BRANCH not taken
        cyc(1);
        check("br_fetch_addr", mem_bus.MEM_ADDR, 16'h0002);
        cyc(3);
        check("br_tk_state", 16'(state), 16'd1);
        check("br_tk_addr",  mem_bus.MEM_ADDR, 16'h0100);
        check("br_tk_pc",    pc, 16'h0100);
        br_taken = 1'b0;
        cyc(3);
        check("br_nt_state", 16'(state), 16'd1);
        check("br_nt_addr",  mem_bus.MEM_ADDR, 16'h0101);
        ea = 16'h0055;

        // STORE 0x9000 to EA=0x0055, zero wait
        cyc(3);
        check("st_mem_state", 16'(state), 16'd4);
        check("st_mem_we",    16'(mem_bus.MEM_WE), 16'd1);
        check("st_mem_addr",  mem_bus.MEM_ADDR, 16'h0055);
        cyc(1);
        check("st_next_state", 16'(state), 16'd1);
        check("st_next_addr",  mem_bus.MEM_ADDR, 16'h0102);
        check("st_next_we",    16'(mem_bus.MEM_WE), 16'd0);

        // RUN dropped during EXECUTE of ALU 0x1111
        cyc(2);
        check("rd_exec_state", 16'(state), 16'd3);
        run = 1'b0;
        cyc(1);
        check("rd_wb_state", 16'(state), 16'd5);
        cyc(1);
        check("rd_idle_state", 16'(state), 16'd0);
        check("rd_idle_req",   16'(mem_bus.MEM_REQ), 16'd0);
        cyc(1);
        check("rd_idle_hold", 16'(state), 16'd0);
        run = 1'b1; br_taken = 1'b1; br_target = 16'hFFFF;

        // Branch to 0xFFFF, fetch NOP, PC wraps to 0x0000
        cyc(1);
        check("wr_fetch_addr", mem_bus.MEM_ADDR, 16'h0103);
        cyc(3);
        check("wr_pc_ffff",   pc, 16'hFFFF);
        check("wr_addr_ffff", mem_bus.MEM_ADDR, 16'hFFFF);
        br_taken = 1'b0;
        cyc(1);
        check("wr_pc_wrap", pc, 16'h0000);
        check("wr_ir_nop",  ir, 16'hE000);
        fetch_delay = 1000;

        // No ack in FETCH: timeout after 15 request cycles
        cyc(2);
        check("to_first_state", 16'(state), 16'd1);
        check("to_first_req",   16'(mem_bus.MEM_REQ), 16'd1);
        cyc(14);
        check("to_last_req", 16'(mem_bus.MEM_REQ), 16'd1);
        check("to_last_err", 16'(err), 16'd0);
        cyc(1);
        check("to_err",    16'(err), 16'd1);
        check("to_halted", 16'(halted), 16'd1);
        check("to_req",    16'(mem_bus.MEM_REQ), 16'd0);
        check("to_state",  16'(state), 16'd6);
        check("to_pc",     pc, 16'h0000);
        check("to_ir",     ir, 16'hE000);
        cyc(3);
        check("to_hold_req",   16'(mem_bus.MEM_REQ), 16'd0);
        check("to_hold_state", 16'(state), 16'd6);
        rst = 1'b1;
        cyc(1);
        check("to_rst_err",    16'(err), 16'd0);
        check("to_rst_halted", 16'(halted), 16'd0);
        check("to_rst_state",  16'(state), 16'd0);

        // Reset while a request is outstanding
        rst = 1'b0;
        cyc(1);
        check("mh_req_up", 16'(mem_bus.MEM_REQ), 16'd1);
        rst = 1'b1;
        cyc(1);
        check("mh_req_drop", 16'(mem_bus.MEM_REQ), 16'd0);
        check("mh_state",    16'(state), 16'd0);

        // HALT opcode; RUN held high must not restart the core
        imem[16'h0000] = 16'hF000;
        fetch_delay = 0;
        rst = 1'b0;
        cyc(4);
        check("ht_state",  16'(state), 16'd6);
        check("ht_halted", 16'(halted), 16'd1);
        check("ht_err",    16'(err), 16'd0);
        check("ht_pc",     pc, 16'h0001);
        cyc(3);
        check("ht_hold_req",    16'(mem_bus.MEM_REQ), 16'd0);
        check("ht_hold_alu_en", 16'(alu_en), 16'd0);
        check("ht_hold_state",  16'(state), 16'd6);
        rst = 1'b1;
        cyc(1);
        check("ht_rst_halted", 16'(halted), 16'd0);
        check("ht_rst_pc",     pc, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
